// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and the iterative multiply/divide unit.
interface muldiv_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             cancel;
   logic             hold;
   logic             stallreq;
   logic             done;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output start, op, src_a, src_b, cancel, hold,
      input  stallreq, done, hi_we, lo_we, hi_o, lo_o
   );

   modport slave (
      input  start, op, src_a, src_b, cancel, hold,
      output stallreq, done, hi_we, lo_we, hi_o, lo_o
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine: one bit per cycle over WIDTH cycles,
// result presented with HI/LO write enables for the done cycle(s).
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   localparam int unsigned CW = $clog2(WIDTH);

   state_t             state;
   logic [CW-1:0]      count;
   logic               is_div;
   logic               neg_res;
   logic               neg_rem;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH:0]     rem;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic               done_r;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] acc_mul_nx;
   logic [WIDTH:0]     shifted;
   logic [WIDTH+1:0]   diff;
   logic               q_bit;
   logic [WIDTH:0]     rem_nx;
   logic [2*WIDTH-1:0] acc_div_nx;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   always_comb begin
      a_neg = ~bus.op[0] & bus.src_a[WIDTH-1];
      b_neg = ~bus.op[0] & bus.src_b[WIDTH-1];
      abs_a = a_neg ? -bus.src_a : bus.src_a;
      abs_b = b_neg ? -bus.src_b : bus.src_b;

      // Multiply: multiplier sits in acc's low half and shifts out LSB first
      // while the partial product grows in from the top.
      mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
      acc_mul_nx = {mul_sum, acc[WIDTH-1:1]};

      // Divide: dividend sits in acc's low half, shifts out MSB first and the
      // quotient bits fill in behind it.
      shifted    = {rem[WIDTH-1:0], acc[WIDTH-1]};
      diff       = {1'b0, shifted} - {2'b00, mag_b};
      q_bit      = ~diff[WIDTH+1];
      rem_nx     = q_bit ? diff[WIDTH:0] : shifted;
      acc_div_nx = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], q_bit};

      prod_fix = neg_res ? -acc_mul_nx : acc_mul_nx;
      quo_fix  = neg_res ? -acc_div_nx[WIDTH-1:0] : acc_div_nx[WIDTH-1:0];
      rem_fix  = neg_rem ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         mag_a   <= '0;
         mag_b   <= '0;
         acc     <= '0;
         rem     <= '0;
         hi_r    <= '0;
         lo_r    <= '0;
         done_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.cancel) begin
                  is_div  <= bus.op[1];
                  neg_res <= a_neg ^ b_neg;
                  neg_rem <= a_neg;
                  mag_a   <= abs_a;
                  mag_b   <= abs_b;
                  count   <= '0;
                  rem     <= '0;
                  acc     <= {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
                  if (bus.op[1] && bus.src_b == '0) begin
                     hi_r   <= bus.src_a;
                     lo_r   <= '1;
                     done_r <= 1'b1;
                     state  <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (bus.cancel) begin
                  state <= IDLE;
               end else begin
                  count <= count + 1'b1;
                  if (is_div) begin
                     acc <= acc_div_nx;
                     rem <= rem_nx;
                  end else begin
                     acc <= acc_mul_nx;
                  end
                  if (count == CW'(WIDTH - 1)) begin
                     state  <= DONE;
                     done_r <= 1'b1;
                     if (is_div) begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                     end else begin
                        hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                     end
                  end
               end
            end
            DONE: begin
               if (bus.cancel || !bus.hold) begin
                  state  <= IDLE;
                  done_r <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.stallreq = ((state == IDLE) && bus.start && !bus.cancel) || (state == CALC);
   assign bus.done     = done_r;
   assign bus.hi_we    = done_r;
   assign bus.lo_we    = done_r;
   assign bus.hi_o     = hi_r;
   assign bus.lo_o     = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes reference results, a negedge
// monitor pops and compares whenever the unit signals done.
module tb_muldiv_unit;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   muldiv_if #(.WIDTH(W)) bus();
   muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
      int          hold;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   len      = 0;
   bit   in_done  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference results straight from MIPS arithmetic on 64-bit integers.
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      longint x, y;
      logic [63:0] p;
      if (op[0]) begin
         x = longint'({32'b0, a});
         y = longint'({32'b0, b});
      end else begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end
      if (!op[1]) begin
         p  = x * y;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 32'b0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
      end else begin
         p  = x % y;
         hi = p[31:0];
         p  = x / y;
         lo = p[31:0];
      end
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.done && sbq.size() == 0) begin
            chk("spurious_done", bus.done, 1'b0);
         end else if (bus.done) begin
            if (!in_done) begin
               chk("latency", cyc, sbq[0].cyc);
               in_done = 1'b1;
               len     = 0;
            end
            len++;
            chk("hi_o", bus.hi_o, sbq[0].hi);
            chk("lo_o", bus.lo_o, sbq[0].lo);
            chk("we_done", {bus.hi_we, bus.lo_we}, 2'b11);
            if (!bus.hold) begin
               chk("done_len", len, sbq[0].hold + 1);
               void'(sbq.pop_front());
               in_done = 1'b0;
            end
         end else begin
            chk("we_idle", {bus.hi_we, bus.lo_we}, 2'b00);
         end
      end
   end

   task automatic scramble();
      bus.op    = 2'($urandom);
      bus.src_a = $urandom;
      bus.src_b = $urandom;
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold_n, input bit poke_start);
      exp_t e;
      bit   div0;
      model(op, a, b, e.hi, e.lo);
      div0      = op[1] && (b == 32'b0);
      e.cyc     = cyc + 1 + (div0 ? 0 : W);
      e.hold    = hold_n;
      sbq.push_back(e);
      bus.op    = op;
      bus.src_a = a;
      bus.src_b = b;
      bus.start = 1'b1;
      bus.cancel = 1'b0;
      bus.hold  = 1'b0;
      #1 chk("stall_accept", bus.stallreq, 1'b1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      scramble();
      if (!div0) begin
         repeat (W) begin
            chk("stall_calc", bus.stallreq, 1'b1);
            @(posedge clk); #1;
         end
      end
      chk("stall_done", bus.stallreq, 1'b0);
      repeat (hold_n) begin
         bus.hold  = 1'b1;
         bus.start = poke_start;
         @(posedge clk); #1;
      end
      bus.hold  = 1'b0;
      bus.start = 1'b0;
      @(posedge clk); #1;
      chk("done_clear", bus.done, 1'b0);
      chk("stall_idle", bus.stallreq, 1'b0);
   endtask

   task automatic run_cancel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int iter);
      bus.op    = op;
      bus.src_a = a;
      bus.src_b = b;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (iter) begin
         @(posedge clk); #1;
      end
      chk("stall_before_cancel", bus.stallreq, 1'b1);
      bus.cancel = 1'b1;
      @(posedge clk); #1;
      bus.cancel = 1'b0;
      chk("stall_after_cancel", bus.stallreq, 1'b0);
      repeat (W + 2) begin
         @(posedge clk); #1;
      end
      chk("no_done_after_cancel", bus.done, 1'b0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      bus.hold   = 1'b0;
      bus.op     = 2'b00;
      bus.src_a  = '0;
      bus.src_b  = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hi", bus.hi_o, 32'h0);
      chk("rst_lo", bus.lo_o, 32'h0);
      chk("rst_done", {bus.done, bus.hi_we, bus.lo_we}, 3'b000);
      chk("rst_stall", bus.stallreq, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 1'b0);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
      run_op(2'b11, 32'd100, 32'd7, 0, 1'b0);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      run_op(2'b10, 32'd5, 32'd0, 0, 1'b0);

      run_cancel(2'b00, 32'd1234, 32'd5678, 10);
      run_op(2'b00, 32'd1234, 32'd5678, 0, 1'b0);

      run_op(2'b11, 32'd1000, 32'd33, 3, 1'b1);

      // start together with cancel in IDLE must not be accepted
      bus.op     = 2'b01;
      bus.src_a  = 32'd9;
      bus.src_b  = 32'd9;
      bus.start  = 1'b1;
      bus.cancel = 1'b1;
      #1 chk("stall_idle_cancel", bus.stallreq, 1'b0);
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      chk("idle_after_cancel_start", bus.stallreq, 1'b0);
      repeat (W + 2) begin
         @(posedge clk); #1;
      end

      // reset in the middle of a multiply
      bus.op    = 2'b01;
      bus.src_a = 32'hDEAD_BEEF;
      bus.src_b = 32'h1234_5678;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_hi", bus.hi_o, 32'h0);
      chk("midrst_lo", bus.lo_o, 32'h0);
      chk("midrst_done", {bus.done, bus.hi_we, bus.lo_we}, 3'b000);
      chk("midrst_stall", bus.stallreq, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 40; i++) begin
         run_op(2'($urandom), pick(), pick(), $urandom_range(0, 2), 1'($urandom));
      end

      repeat (3) @(posedge clk);
      #1 chk("scoreboard_empty", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
